// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the dual-read scratch RAM with clear engine.
//   ram_state_t      : clear-engine state (IDLE, CLEAR)
//   RAM_ADDR_W_DEF   : default address width
//   RAM_DATA_W_DEF   : default word width
//   SEG_TABLE        : 16-entry seven-segment pattern table, bit order {dp,g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic {IDLE, CLEAR} ram_state_t;

  localparam int RAM_ADDR_W_DEF = 2;
  localparam int RAM_DATA_W_DEF = 4;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,
    8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C,
    8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/ram_dual_rd_clr_hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg
// Purely combinational hex digit to seven-segment pattern decoder.
//   hex : in  4  hex digit
//   seg : out 8  segment pattern {dp,g,f,e,d,c,b,a}, active high
// ----------------------------------------------------------------------------
module hex7seg
  import ram_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Straight table lookup; the table lives in the package so every display
  // block in the design shows the same glyphs.
  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ram_dual_rd_clr.sv
// ----------------------------------------------------------------------------
// ram_dual_rd_clr
// 2**ADDR_W x DATA_W scratch RAM with one synchronous write port, two
// registered read ports and a clear engine that zeroes the array one word per
// cycle after reset release and on request.
//
// Ports:
//   clk_2      in   1       clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   wr_en      in   1       write strobe
//   wr_addr    in   ADDR_W  write address
//   wr_data    in   DATA_W  write data
//   rd_en      in   1       read strobe, samples both read ports
//   rd_addr_a  in   ADDR_W  port A read address
//   rd_addr_b  in   ADDR_W  port B read address
//   rd_data_a  out  DATA_W  port A registered read data
//   rd_data_b  out  DATA_W  port B registered read data
//   rd_valid   out  1       pulse: rd_data_a/b updated this cycle
//   clr_req    in   1       request a full-array clear
//   busy       out  1       clear sweep in progress
//   clr_done   out  1       pulse at end of a sweep
//   seg_a      out  8       (RAM_HEX_SEG_EN only) seven-segment view of rd_data_a[3:0]
//
// Build option: define RAM_HEX_SEG_EN to add the seg_a output and decoder.
// ----------------------------------------------------------------------------
module ram_dual_rd_clr
  import ram_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W_DEF,
  parameter int DATA_W   = RAM_DATA_W_DEF,
  parameter int WR_FIRST = 1
)(
  input  logic              clk_2,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
`ifdef RAM_HEX_SEG_EN
  ,
  output logic [7:0]        seg_a
`endif
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              clr_done_nxt;
  logic              idle;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_word_a;
  logic [DATA_W-1:0] rd_word_b;

  // User traffic is only honoured in IDLE, and a clear request in the same
  // cycle takes priority over both the write and the read.
  assign idle    = (state == IDLE);
  assign wr_fire = idle & wr_en & ~clr_req;
  assign rd_fire = idle & rd_en & ~clr_req;
  assign busy    = (state == CLEAR);

  // Next-state logic for the clear engine. The sweep ends on the compare with
  // the last address rather than on wrap-around, so clr_addr can stay
  // ADDR_W bits wide.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = IDLE;
          clr_done_nxt = 1'b1;
        end
      end
    endcase
  end

  // State register. Reset parks the engine in CLEAR at address 0 so a full
  // sweep runs automatically once reset is released.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  // Storage array. It has no reset of its own; the sweep is the only thing
  // that zeroes it, and user writes are locked out while it runs.
  always_ff @(posedge clk_2) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read word selection. With WR_FIRST set, a write to the same address on
  // the same edge is forwarded so the port sees the new data; otherwise the
  // port sees the array contents from before the edge.
  always_comb begin
    rd_word_a = mem[rd_addr_a];
    rd_word_b = mem[rd_addr_b];
    if ((WR_FIRST != 0) && wr_fire && (wr_addr == rd_addr_a)) begin
      rd_word_a = wr_data;
    end
    if ((WR_FIRST != 0) && wr_fire && (wr_addr == rd_addr_b)) begin
      rd_word_b = wr_data;
    end
  end

  // Registered read ports. Data holds whenever no read fires, and rd_valid
  // flags exactly the cycles in which fresh data appears.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data_a <= rd_word_a;
        rd_data_b <= rd_word_b;
      end
    end
  end

`ifdef RAM_HEX_SEG_EN
  logic [3:0] seg_nibble;

  // Low nibble of port A drives the display; since rd_data_a resets to zero
  // the display shows "0" while reset is held.
  assign seg_nibble = 4'(rd_data_a);

  hex7seg u_hex7seg (
    .hex (seg_nibble),
    .seg (seg_a)
  );
`endif

endmodule

// File: doc/ram_dual_rd_clr.md
Name: ram_dual_rd_clr

Overview:
- Parametrised successor to the board-level 4x4 scratch RAM.
- Storage: 2**ADDR_W words of DATA_W bits.
- Ports: one synchronous write port and two registered read ports (A and B).
- Clear engine: a state machine zeroes the whole array one word per cycle, automatically after reset and on request. A busy/done handshake tells the top level when the array may be used.
- Sits between the SWI-driven control logic in top and the LED/SEG/LCD display outputs.

Parameters:
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W.
- DATA_W, 4, word width in bits.
- WR_FIRST, 1, read-during-write policy. 1 = read returns the new data; 0 = read returns the old contents.

Ports:
- clk_2  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe; samples both read ports.
- rd_addr_a  in  ADDR_W  port A read address.
- rd_addr_b  in  ADDR_W  port B read address.
- rd_data_a  out  DATA_W  port A registered read data.
- rd_data_b  out  DATA_W  port B registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data_a/b updated this cycle.
- clr_req  in  1  request a full-array clear.
- busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse at end of a sweep.

Behaviour:
- Reset: one clock, clk_2; reset is asynchronous and active-low (reset=0 resets).
- Reset values:
  - rd_data_a = rd_data_b = 0.
  - rd_valid = 0, clr_done = 0.
  - state = CLEAR, clr_addr = 0, busy = 1.
  - Array contents are not touched asynchronously; they are zeroed by the sweep that follows reset release.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a clr_req sampled high; clr_addr is loaded with 0.
  - CLEAR: each edge writes 0 to mem[clr_addr] and increments clr_addr.
  - The edge that writes address DEPTH-1 moves to IDLE and sets clr_done = 1 for exactly one cycle.
  - busy = (state == CLEAR). busy is high for exactly DEPTH cycles after acceptance or reset release.
- Write: in IDLE, wr_en=1 writes mem[wr_addr] <= wr_data at the edge. Latency 1.
- Read:
  - In IDLE, rd_en=1 registers both ports at the edge; rd_valid=1 in the next cycle. Latency 1.
  - When rd_en=0, rd_data_a/b hold their value and rd_valid=0.
- Read-during-write, same address, same edge: with WR_FIRST=1 the port returns wr_data; with WR_FIRST=0 it returns the old word. Applies independently to A and B.
- Both read ports at the same address return the same word.
- While busy=1:
  - wr_en, rd_en and clr_req are ignored.
  - rd_valid stays 0 and rd_data holds.
- clr_req together with wr_en/rd_en in IDLE: the clear wins; the write and read are dropped and rd_valid stays 0.
- Reset asserted mid-sweep or mid-read: outputs return to reset values immediately; the sweep restarts from address 0 after release.
- Address arithmetic: clr_addr is ADDR_W bits; the sweep terminates on the compare with DEPTH-1, not on wrap-around.

Optional Feature:
- Macro: RAM_HEX_SEG_EN.
- When defined:
  - Adds output port seg_a (out, 8): seven-segment pattern of rd_data_a[3:0], using the team hex table. Examples: 0 -> 00111111, A -> 01110111, F -> 01110001.
  - seg_a is combinational from the registered rd_data_a; it is 00111111 during reset.
- When undefined: the port and decoder are absent; the rest of the behaviour is identical.

Decomposition:
- Package ram_pkg:
  - typedef enum logic {IDLE, CLEAR} ram_state_t.
  - Default constants for ADDR_W/DATA_W.
  - The 16-entry seven-segment constant table.
- Sub-module hex7seg: 4-bit in, 8-bit segment out, purely combinational. Instantiated only under RAM_HEX_SEG_EN.

Test Plan:
All cases use ADDR_W=2, DATA_W=4.
1. Reset low 3 cycles, then release -> busy=1 for 4 cycles, clr_done pulses once; then read all addresses -> every word is 0.
2. Write 5 to address 2, then rd_en with rd_addr_a=2, rd_addr_b=0 -> next cycle rd_valid=1, rd_data_a=5, rd_data_b=0.
3. mem[1]=3, then same edge wr_en to address 1 with data 9 and rd_en with rd_addr_a=1:
   - WR_FIRST=1 -> rd_data_a=9.
   - WR_FIRST=0 -> rd_data_a=3, and a later read returns 9.
4. Fill addresses 0..3 with F, pulse clr_req, and pulse wr_en/rd_en during busy -> writes/reads dropped, rd_valid=0, all words read back 0 after clr_done.
5. Assert reset at the 2nd sweep cycle -> busy and outputs return to reset values immediately; after release the sweep takes a full 4 cycles.
6. With RAM_HEX_SEG_EN defined, write A to address 3 and read it -> seg_a=01110111.
